// File: rtl/data_cache_pkg.sv
// data_cache_pkg: shared definitions for the data cache.
//   - state_t: controller states (IDLE, WRITEBACK, ALLOCATE, WAIT_FILL)
//   - default geometry (line size, set count)
//   - address-field width helpers (offset, word select, index, tag)
package data_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    WAIT_FILL = 2'd3
  } state_t;

  localparam int DEF_LINE_BYTES = 16;
  localparam int DEF_NUM_SETS   = 16;
  localparam int WORD_BYTES     = 4;
  localparam int ADDR_W         = 32;

  function automatic int offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int word_sel_w(input int line_bytes);
    return $clog2(line_bytes / WORD_BYTES);
  endfunction

  function automatic int index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_w(input int line_bytes, input int num_sets);
    return ADDR_W - offset_w(line_bytes) - index_w(num_sets);
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// data_cache_array: per-set valid/dirty/tag/line storage.
// Ports:
//   clk, reset          clock, synchronous active-high reset (clears valid/dirty)
//   rd_index            combinational read select -> rd_valid/rd_dirty/rd_tag/rd_line
//   wr_en/wr_index/wr_word/wr_data   single-word store, marks the set dirty
//   fill_en/fill_index/fill_tag/fill_line   full-line install, valid=1 dirty=0
//   clean_en/clean_index                     clears dirty after a writeback
module data_cache_array
  import data_cache_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [index_w(NUM_SETS)-1:0]          rd_index,
  output logic                                  rd_valid,
  output logic                                  rd_dirty,
  output logic [tag_w(LINE_BYTES,NUM_SETS)-1:0] rd_tag,
  output logic [LINE_BYTES*8-1:0]               rd_line,
  input  logic                                  wr_en,
  input  logic [index_w(NUM_SETS)-1:0]          wr_index,
  input  logic [word_sel_w(LINE_BYTES)-1:0]     wr_word,
  input  logic [31:0]                           wr_data,
  input  logic                                  fill_en,
  input  logic [index_w(NUM_SETS)-1:0]          fill_index,
  input  logic [tag_w(LINE_BYTES,NUM_SETS)-1:0] fill_tag,
  input  logic [LINE_BYTES*8-1:0]               fill_line,
  input  logic                                  clean_en,
  input  logic [index_w(NUM_SETS)-1:0]          clean_index
);

  localparam int TAG_W = tag_w(LINE_BYTES, NUM_SETS);

  logic [NUM_SETS-1:0]     valid_q;
  logic [NUM_SETS-1:0]     dirty_q;
  logic [TAG_W-1:0]        tag_q  [NUM_SETS];
  logic [LINE_BYTES*8-1:0] data_q [NUM_SETS];

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_line  = data_q[rd_index];

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      if (clean_en) dirty_q[clean_index] <= 1'b0;
      if (fill_en) begin
        valid_q[fill_index] <= 1'b1;
        dirty_q[fill_index] <= 1'b0;
      end
      if (wr_en) dirty_q[wr_index] <= 1'b1;
    end
  end

  // Tag/data contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_line;
    end
    if (wr_en) data_q[wr_index][32*int'(wr_word) +: 32] <= wr_data;
  end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-back, write-allocate data cache.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   is_input_valid/addr/mem_read/mem_write/din   MEM-stage request
//   is_ready/is_output_valid/dout/is_hit         MEM-stage response
//   mem_req_* / mem_resp_*          line-wide valid/ready backing-memory port
//   hit_count/miss_count            present only with DCACHE_STATS_EN defined
//
// state     | meaning
// IDLE      | accept requests; hits complete combinationally; also replay cycle
// WRITEBACK | posting dirty victim line to memory
// ALLOCATE  | issuing line read for the missed address
// WAIT_FILL | waiting for refill data; install it, then replay in IDLE
module data_cache
  import data_cache_pkg::*;
#(
  parameter int LINE_BYTES = DEF_LINE_BYTES,
  parameter int NUM_SETS   = DEF_NUM_SETS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [31:0]             din,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic [31:0]             dout,
  output logic                    is_hit,
  output logic                    mem_req_valid,
  output logic                    mem_req_we,
  output logic [31:0]             mem_req_addr,
  output logic [LINE_BYTES*8-1:0] mem_req_wdata,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             hit_count,
  output logic [31:0]             miss_count
`endif
);

  localparam int OFF_W  = offset_w(LINE_BYTES);
  localparam int WSEL_W = word_sel_w(LINE_BYTES);
  localparam int IDX_W  = index_w(NUM_SETS);
  localparam int TAG_W  = tag_w(LINE_BYTES, NUM_SETS);
  localparam int LINE_W = LINE_BYTES * 8;

  state_t state, state_next;

  // replay marks the IDLE cycle right after a fill, when the latched
  // request is looked up again instead of the live inputs.
  logic        replay;
  logic [31:0] req_addr;
  logic [31:0] req_din;
  logic        req_read;
  logic        req_write;

  logic [31:0] lk_addr;
  logic [31:0] lk_din;
  logic        lk_read, lk_write, lk_valid;
  logic [IDX_W-1:0]  lk_index, req_index, rd_index;
  logic [TAG_W-1:0]  lk_tag, req_tag;
  logic [WSEL_W-1:0] lk_word;

  logic              rd_valid, rd_dirty, lk_match;
  logic [TAG_W-1:0]  rd_tag;
  logic [LINE_W-1:0] rd_line;

  logic latch_en, wr_en, fill_en, clean_en, miss_start;
  logic unused_bits;

  assign lk_addr  = replay ? req_addr  : addr;
  assign lk_din   = replay ? req_din   : din;
  assign lk_read  = replay ? req_read  : mem_read;
  assign lk_write = replay ? req_write : mem_write;
  assign lk_valid = replay | is_input_valid;

  assign lk_index  = lk_addr[OFF_W +: IDX_W];
  assign lk_tag    = lk_addr[31 -: TAG_W];
  assign lk_word   = lk_addr[2 +: WSEL_W];
  assign req_index = req_addr[OFF_W +: IDX_W];
  assign req_tag   = req_addr[31 -: TAG_W];

  // Outside IDLE the array is addressed by the latched request (victim read).
  assign rd_index = (state == IDLE) ? lk_index : req_index;
  assign lk_match = rd_valid && (rd_tag == lk_tag);
  assign is_ready = (state == IDLE);

  assign unused_bits = ^{lk_addr[1:0], req_addr[1:0]};

  data_cache_array #(
    .LINE_BYTES (LINE_BYTES),
    .NUM_SETS   (NUM_SETS)
  ) u_array (
    .clk         (clk),
    .reset       (reset),
    .rd_index    (rd_index),
    .rd_valid    (rd_valid),
    .rd_dirty    (rd_dirty),
    .rd_tag      (rd_tag),
    .rd_line     (rd_line),
    .wr_en       (wr_en),
    .wr_index    (lk_index),
    .wr_word     (lk_word),
    .wr_data     (lk_din),
    .fill_en     (fill_en),
    .fill_index  (req_index),
    .fill_tag    (req_tag),
    .fill_line   (mem_resp_data),
    .clean_en    (clean_en),
    .clean_index (req_index)
  );

  always_comb begin
    state_next      = state;
    is_output_valid = 1'b0;
    is_hit          = 1'b0;
    dout            = '0;
    mem_req_valid   = 1'b0;
    mem_req_we      = 1'b0;
    mem_req_addr    = '0;
    mem_req_wdata   = '0;
    latch_en        = 1'b0;
    miss_start      = 1'b0;
    wr_en           = 1'b0;
    fill_en         = 1'b0;
    clean_en        = 1'b0;
    case (state)
      IDLE: begin
        if (lk_valid) begin
          if (!lk_read && !lk_write) begin
            is_output_valid = 1'b1;
            is_hit          = 1'b1;
          end else if (lk_match) begin
            is_output_valid = 1'b1;
            is_hit          = !replay;
            wr_en           = lk_write;
            if (!lk_write) dout = rd_line[32*int'(lk_word) +: 32];
          end else begin
            latch_en   = 1'b1;
            miss_start = 1'b1;
            state_next = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        mem_req_valid = 1'b1;
        mem_req_we    = 1'b1;
        mem_req_addr  = {rd_tag, req_index, {OFF_W{1'b0}}};
        mem_req_wdata = rd_line;
        if (mem_req_ready) begin
          clean_en   = 1'b1;
          state_next = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
        if (mem_req_ready) state_next = WAIT_FILL;
      end
      WAIT_FILL: begin
        if (mem_resp_valid) begin
          fill_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      replay <= 1'b0;
    end else begin
      state  <= state_next;
      replay <= (state == WAIT_FILL) && mem_resp_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (latch_en) begin
      req_addr  <= addr;
      req_din   <= din;
      req_read  <= mem_read;
      req_write <= mem_write;
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (is_output_valid && is_hit && (lk_read || lk_write)) hit_count <= hit_count + 32'd1;
      if (miss_start) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic         clk;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read;
  logic         mem_write;
  logic [31:0]  din;
  logic         is_ready;
  logic         is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_req_valid;
  logic         mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wdata;
  logic         mem_req_ready;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_data;
`ifdef DCACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Results captured by do_access
  int           res_cycles;
  logic         res_done;
  logic [31:0]  res_dout;
  logic         res_hit;
  logic         wb_seen;
  logic [31:0]  wb_addr;
  logic [127:0] wb_data;
  logic         alloc_seen;
  logic [31:0]  alloc_addr;

  data_cache dut (
    .clk             (clk),
    .reset           (reset),
    .is_input_valid  (is_input_valid),
    .addr            (addr),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .din             (din),
    .is_ready        (is_ready),
    .is_output_valid (is_output_valid),
    .dout            (dout),
    .is_hit          (is_hit),
    .mem_req_valid   (mem_req_valid),
    .mem_req_we      (mem_req_we),
    .mem_req_addr    (mem_req_addr),
    .mem_req_wdata   (mem_req_wdata),
    .mem_req_ready   (mem_req_ready),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and act as the backing memory until completion.
  // lat: cycles from the read handshake to the response cycle.
  // hold: cycles mem_req_ready stays low on the first memory request.
  task automatic do_access(input logic [31:0] a, input logic r, input logic w,
                           input logic [31:0] d, input logic [127:0] fill,
                           input int lat, input int hold);
    int hs_cyc;
    int held;
    logic hold_done;
    logic snap_we;
    logic [31:0] snap_addr;
    logic [127:0] snap_wdata;
    @(negedge clk);
    is_input_valid = 1'b1;
    addr           = a;
    mem_read       = r;
    mem_write      = w;
    din            = d;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = fill;
    res_done   = 1'b0;
    res_cycles = -1;
    res_dout   = '0;
    res_hit    = 1'b0;
    wb_seen    = 1'b0;
    wb_addr    = '0;
    wb_data    = '0;
    alloc_seen = 1'b0;
    alloc_addr = '0;
    hs_cyc     = -1000;
    held       = 0;
    hold_done  = (hold == 0);
    snap_we    = 1'b0;
    snap_addr  = '0;
    snap_wdata = '0;
    for (int cyc = 0; cyc < 60 && !res_done; cyc++) begin
      mem_resp_valid = (cyc == hs_cyc + lat);
      #1;
      mem_req_ready = 1'b0;
      if (is_output_valid) begin
        res_done   = 1'b1;
        res_cycles = cyc;
        res_dout   = dout;
        res_hit    = is_hit;
      end else if (mem_req_valid) begin
        if (!hold_done) begin
          if (held == 0) begin
            snap_we    = mem_req_we;
            snap_addr  = mem_req_addr;
            snap_wdata = mem_req_wdata;
          end else begin
            check("hold_we", mem_req_we, snap_we);
            check("hold_addr", mem_req_addr, snap_addr);
            check("hold_wdata", mem_req_wdata, snap_wdata);
          end
          if (held >= hold) hold_done = 1'b1;
          held++;
        end
        if (hold_done) begin
          mem_req_ready = 1'b1;
          if (mem_req_we) begin
            wb_seen = 1'b1;
            wb_addr = mem_req_addr;
            wb_data = mem_req_wdata;
          end else begin
            alloc_seen = 1'b1;
            alloc_addr = mem_req_addr;
            hs_cyc     = cyc;
          end
        end
      end
      if (!res_done) @(negedge clk);
    end
    check("access_done", res_done, 1'b1);
    @(posedge clk);
    #1;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  localparam logic [127:0] L100 = 128'h11110003_11110002_11110001_11110000;
  localparam logic [127:0] L200 = 128'h22220003_22220002_22220001_22220000;
  localparam logic [127:0] L300 = 128'h33330003_33330002_33330001_33330000;
  localparam logic [127:0] L100B = 128'h11110003_11110002_11110001_DEADBEEF;

  initial begin
    reset          = 1'b1;
    is_input_valid = 1'b0;
    addr           = '0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    din            = '0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_is_ready", is_ready, 1'b1);
    check("rst_out_valid", is_output_valid, 1'b0);
    check("rst_is_hit", is_hit, 1'b0);
    check("rst_dout", dout, 32'h0);
    check("rst_req_valid", mem_req_valid, 1'b0);
    check("rst_req_we", mem_req_we, 1'b0);
    check("rst_req_addr", mem_req_addr, 32'h0);
    check("rst_req_wdata", mem_req_wdata, 128'h0);

    // Cold load miss, latency 3
    do_access(32'h100, 1'b1, 1'b0, 32'h0, L100, 3, 0);
    check("cold_cycles", res_cycles, 5);
    check("cold_alloc_addr", alloc_addr, 32'h100);
    check("cold_no_wb", wb_seen, 1'b0);
    check("cold_dout", res_dout, 32'h11110000);
    check("cold_hit", res_hit, 1'b0);

    // Load hit on word 1
    do_access(32'h104, 1'b1, 1'b0, 32'h0, L100, 3, 0);
    check("hit_cycles", res_cycles, 0);
    check("hit_flag", res_hit, 1'b1);
    check("hit_dout", res_dout, 32'h11110001);

    // No-op request completes at once
    do_access(32'h104, 1'b0, 1'b0, 32'h0, L100, 3, 0);
    check("nop_cycles", res_cycles, 0);
    check("nop_hit", res_hit, 1'b1);

    // Store hit
    do_access(32'h100, 1'b0, 1'b1, 32'hDEADBEEF, L100, 3, 0);
    check("st_hit_cycles", res_cycles, 0);
    check("st_hit_flag", res_hit, 1'b1);
    check("st_hit_dout", res_dout, 32'h0);

    // Conflict load miss with dirty victim, latency 2
    do_access(32'h200, 1'b1, 1'b0, 32'h0, L200, 2, 0);
    check("dirty_wb_seen", wb_seen, 1'b1);
    check("dirty_wb_addr", wb_addr, 32'h100);
    check("dirty_wb_w0", wb_data[31:0], 32'hDEADBEEF);
    check("dirty_wb_w1", wb_data[63:32], 32'h11110001);
    check("dirty_alloc_addr", alloc_addr, 32'h200);
    check("dirty_cycles", res_cycles, 5);
    check("dirty_dout", res_dout, 32'h22220000);
    check("dirty_hit", res_hit, 1'b0);

    // Store miss on clean victim, latency 1
    do_access(32'h300, 1'b0, 1'b1, 32'hCAFEF00D, L300, 1, 0);
    check("stmiss_no_wb", wb_seen, 1'b0);
    check("stmiss_alloc", alloc_addr, 32'h300);
    check("stmiss_cycles", res_cycles, 3);
    check("stmiss_hit", res_hit, 1'b0);

    // Merged word visible
    do_access(32'h300, 1'b1, 1'b0, 32'h0, L300, 1, 0);
    check("merge_cycles", res_cycles, 0);
    check("merge_dout", res_dout, 32'hCAFEF00D);

    // Dirty 0x300 evicted with ready held low for 4 cycles
    do_access(32'h104, 1'b1, 1'b0, 32'h0, L100B, 1, 4);
    check("hold_wb_seen", wb_seen, 1'b1);
    check("hold_wb_addr", wb_addr, 32'h300);
    check("hold_wb_w0", wb_data[31:0], 32'hCAFEF00D);
    check("hold_wb_w1", wb_data[63:32], 32'h33330001);
    check("hold_alloc", alloc_addr, 32'h100);
    check("hold_cycles", res_cycles, 8);
    check("hold_dout", res_dout, 32'h11110001);

    // Other index, cold miss
    do_access(32'h01C, 1'b1, 1'b0, 32'h0, L300, 2, 0);
    check("idx1_alloc", alloc_addr, 32'h010);
    check("idx1_cycles", res_cycles, 4);
    check("idx1_dout", res_dout, 32'h33330003);

    // Reset during WAIT_FILL
    @(negedge clk);
    is_input_valid = 1'b1;
    addr           = 32'h500;
    mem_read       = 1'b1;
    @(negedge clk);
    #1;
    check("rmid_alloc_valid", mem_req_valid, 1'b1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    #1;
    check("rmid_wf_ready", is_ready, 1'b0);
    reset          = 1'b1;
    is_input_valid = 1'b0;
    mem_read       = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("rmid_req_valid", mem_req_valid, 1'b0);
    check("rmid_is_ready", is_ready, 1'b1);
    check("rmid_out_valid", is_output_valid, 1'b0);

    do_access(32'h100, 1'b1, 1'b0, 32'h0, L100, 3, 0);
    check("post_rst_cycles", res_cycles, 5);
    check("post_rst_hit", res_hit, 1'b0);
    check("post_rst_alloc", alloc_addr, 32'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage and a multi-cycle backing data memory. Accepts one word load/store per request from the MEM stage, answers hits in the request cycle, and runs a line writeback/refill over a valid/ready memory port on misses. The pipeline stalls IF/ID/EX/MEM whenever a MEM-stage access is outstanding (`is_output_valid` low).

## Interface
- `LINE_BYTES`, default 16: line size in bytes, power of two, ≥ 8.
- `NUM_SETS`, default 16: number of sets, power of two.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `is_input_valid` in 1: MEM stage presents a request.
- `addr` in 32: byte address, word-aligned (`addr[1:0]` ignored).
- `mem_read` in 1: load request.
- `mem_write` in 1: store request; takes priority if both set.
- `din` in 32: store data.
- `is_ready` out 1: cache is in IDLE and can accept a request.
- `is_output_valid` out 1: request done this cycle; `dout` valid for loads.
- `dout` out 32: load data.
- `is_hit` out 1: request hit on first lookup; qualified by `is_output_valid`.
- `mem_req_valid` out 1: backing-memory request.
- `mem_req_we` out 1: 1 = line write, 0 = line read.
- `mem_req_addr` out 32: line-aligned byte address.
- `mem_req_wdata` out LINE_BYTES*8: writeback line.
- `mem_req_ready` in 1: memory accepts the request this cycle.
- `mem_resp_valid` in 1: refill data valid, one cycle.
- `mem_resp_data` in LINE_BYTES*8: refill line.

## Operation
- Address split: offset = log2(LINE_BYTES) bits, of which the upper bits select the word; index = log2(NUM_SETS) bits; tag = the remaining upper bits.
- Per set: valid bit, dirty bit, tag, line data. Reset clears all valid and dirty bits; data and tag contents are don't-care.
- FSM states: IDLE, WRITEBACK, ALLOCATE, WAIT_FILL.
  - IDLE: `is_ready`=1. On `is_input_valid` with neither `mem_read` nor `mem_write`, assert `is_output_valid`=1, `is_hit`=1, and stay in IDLE.
  - IDLE, hit (valid and tag match): `is_output_valid`=1, `is_hit`=1. A load drives the selected word on `dout`. A store writes `din` into the word and sets dirty at the clock edge. Stay in IDLE.
  - IDLE, miss: latch the request. Go to WRITEBACK if the victim is valid and dirty, otherwise go to ALLOCATE.
  - WRITEBACK: `mem_req_valid`=1, `mem_req_we`=1, address = {victim tag, index, 0}, data = victim line. On `mem_req_ready`, clear dirty and go to ALLOCATE. Writes are posted; there is no response.
  - ALLOCATE: `mem_req_valid`=1, `mem_req_we`=0, address = requested line. On `mem_req_ready`, go to WAIT_FILL.
  - WAIT_FILL: on `mem_resp_valid`, install the line, set valid, set the tag, clear dirty, and return to IDLE. The replayed lookup then hits, completes with `is_hit`=0, and applies store merge and dirty as for a normal hit.
- Requester contract:
  - `addr`, `mem_read`, `mem_write` and `din` stay stable from acceptance until `is_output_valid`.
  - `is_input_valid` stays high for that whole interval.
  - The cache latches the request internally and does not rely on these inputs remaining stable.
- `mem_req_*` outputs hold stable while `mem_req_valid`=1 and `mem_req_ready`=0.
- A `mem_resp_valid` outside WAIT_FILL is ignored.

## Timing
- Reset values: `is_ready`=1, `is_output_valid`=0, `is_hit`=0, `dout`=0, `mem_req_valid`=0, `mem_req_we`=0, `mem_req_addr`=0, `mem_req_wdata`=0. State = IDLE.
- Hit: 0-cycle latency. Outputs are combinational from the request and the arrays; the store commits at the same edge.
- Clean miss: 1 cycle (ALLOCATE, ready immediately) + memory response latency + 1 replay cycle.
- Dirty miss: clean-miss timing + one WRITEBACK handshake.
- `is_hit` marks a replay completion as a miss (`is_hit`=0), not as a hit.
- Reset mid-miss: abort at the edge, drop `mem_req_valid` in the next cycle, clear all valid bits, discard the pending request.
- Back-to-back hits complete one per cycle.
- Conflict miss on the same index evicts the victim; a store miss to a dirty victim writes back first.

## Configuration
- `DCACHE_STATS_EN` defined:
  - Adds outputs `hit_count` and `miss_count`, each 32 bits, wrapping.
  - `hit_count` increments on each completion with `is_hit`=1 and a load or store.
  - `miss_count` increments on each IDLE-to-miss transition.
  - Both counters clear on reset.
- `DCACHE_STATS_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package holds:
  - FSM state typedef (IDLE/WRITEBACK/ALLOCATE/WAIT_FILL).
  - Default geometry constants.
  - Address-field width functions: tag, index, offset, word-select widths.
- Sub-module `data_cache_array`: valid/dirty/tag/data storage with combinational read, a one-word write port and a full-line fill port. The FSM and handshakes live in the top.

## Test plan
- Reset, then load 0x100 (cold miss, memory latency 3) → `mem_req_addr`=0x100, we=0, `is_output_valid` exactly 5 cycles after the request. `dout` = word 0 of the fill line, `is_hit`=0.
- Load 0x104 after the above → same cycle, `is_output_valid`=1, `is_hit`=1, `dout` = word 1 of the fill line.
- Store 0xDEADBEEF to 0x100 (hit), then load 0x200 → one WRITEBACK at address 0x100 whose word 0 = 0xDEADBEEF, then ALLOCATE at address 0x200.
- Store miss to 0x300 on a clean victim → read-only refill, merged word visible on the next load of 0x300, line marked dirty.
- Hold `mem_req_ready`=0 for 4 cycles → `mem_req_*` stable throughout.
- Assert reset during WAIT_FILL → `mem_req_valid`=0 and `is_ready`=1 after reset, then a load of 0x100 misses.
